// File: rtl/psubsb_seq_pkg.sv
// Shared 4-bit lane ALU definitions: saturation constants, FSM encoding and
// a carry-lookahead adder helper used by the add and subtract lanes.
package psubsb_seq_pkg;

  localparam int LANE_W = 4;

  localparam logic [LANE_W-1:0] SAT_POS_4 = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG_4 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // 4-bit carry-lookahead sum; carry-out is not needed by the saturating lanes.
  function automatic logic [LANE_W-1:0] cla4_sum(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b,
                                                 input logic cin);
    logic [LANE_W-1:0] g;
    logic [LANE_W-1:0] p;
    logic [LANE_W-1:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return p ^ c;
  endfunction

endpackage

// File: rtl/psubsb_seq_lane.sv
// One signed 4-bit lane of the packed saturating subtractor: a - b clamped
// to [-8, +7], with a flag when clamping happened.
module psubsb_lane
  import psubsb_seq_pkg::*;
(
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] result_o,
  output logic              ovf_o
);

  logic [LANE_W-1:0] diff;
  logic              pos_sat;
  logic              neg_sat;

  assign diff = cla4_sum(a_i, ~b_i, 1'b1);

  // Overflow only when operand signs differ and the raw sign disagrees with a.
  assign pos_sat = ~a_i[3] &  b_i[3] &  diff[3];
  assign neg_sat =  a_i[3] & ~b_i[3] & ~diff[3];

  always_comb begin
    result_o = diff;
    if (pos_sat) begin
      result_o = SAT_POS_4;
    end else if (neg_sat) begin
      result_o = SAT_NEG_4;
    end
  end

  assign ovf_o = pos_sat | neg_sat;

endmodule

// File: rtl/psubsb_seq.sv
// Lane-serial packed saturating subtractor: accepts two packed words, resolves
// one 4-bit lane per cycle and holds the packed result until the consumer takes it.
module psubsb_seq
  import psubsb_seq_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W*LANES-1:0]   in_a,
  input  logic [LANE_W*LANES-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W*LANES-1:0]   out_result,
  output logic [LANES-1:0]          out_ovf
);

  localparam int W     = LANE_W * LANES;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  lane_idx_q, lane_idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      result_q, result_d;
  logic [LANES-1:0]  ovf_q, ovf_d;

  logic [LANES-1:0]  lane_sel;
  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b;
  logic [LANE_W-1:0] lane_res;
  logic              lane_ovf;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_sel
    assign lane_sel[gi] = (lane_idx_q == IDX_W'(gi));
  end

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_sel[i]) begin
        lane_a = a_q[i*LANE_W +: LANE_W];
        lane_b = b_q[i*LANE_W +: LANE_W];
      end
    end
  end

  psubsb_lane u_lane (
    .a_i      (lane_a),
    .b_i      (lane_b),
    .result_o (lane_res),
    .ovf_o    (lane_ovf)
  );

  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = in_b;
          result_d   = '0;
          ovf_d      = '0;
          lane_idx_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_sel[i]) begin
            result_d[i*LANE_W +: LANE_W] = lane_res;
            ovf_d[i]                     = lane_ovf;
          end
        end
        if (lane_idx_q == LAST_IDX) begin
          lane_idx_d = '0;
          state_d    = DONE;
        end else begin
          lane_idx_d = lane_idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_psubsb_seq.sv
// Scoreboard bench for psubsb_seq: driver pushes model results, a negedge
// monitor pops and checks results, latency, hold stability and handshake release.
module tb_psubsb_seq;

  localparam int LANES = 4;
  localparam int W     = 4 * LANES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_result;
  logic [LANES-1:0] out_ovf;

  psubsb_seq #(.LANES(LANES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     res;
    logic [LANES-1:0] ovf;
    int               acc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  bit   bp_mode = 1'b0;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) out_ready = 1'($urandom_range(0, 1));
  end

  // Reference: signed integer subtraction, clamped to the 4-bit signed range.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    int   sa, sb, d;
    e.res = '0;
    e.ovf = '0;
    e.acc = acc;
    for (int i = 0; i < LANES; i++) begin
      sa = int'($signed(a[4*i +: 4]));
      sb = int'($signed(b[4*i +: 4]));
      d  = sa - sb;
      if (d > 7) begin
        d = 7;
        e.ovf[i] = 1'b1;
      end else if (d < -8) begin
        d = -8;
        e.ovf[i] = 1'b1;
      end
      e.res[4*i +: 4] = 4'(d);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor
  initial begin
    bit   prev_valid;
    bit   hs_pending;
    exp_t cur;
    prev_valid = 1'b0;
    hs_pending = 1'b0;
    cur.res = '0;
    cur.ovf = '0;
    cur.acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        hs_pending = 1'b0;
      end else begin
        if (hs_pending) begin
          check("valid_drop_after_accept", 32'(out_valid), 32'd0);
          check("in_ready_after_accept", 32'(in_ready), 32'd1);
        end
        if (out_valid) begin
          if (!prev_valid) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid: got out_result=%h with no op pending, expected no out_valid", out_result);
              cur.res = out_result;
              cur.ovf = out_ovf;
            end else begin
              cur = sb_q.pop_front();
              check("out_result", 32'(out_result), 32'(cur.res));
              check("out_ovf", 32'(out_ovf), 32'(cur.ovf));
              check("latency", 32'(cycle - cur.acc), 32'(LANES));
              $display("op done: result=%h ovf=%b latency=%0d", out_result, out_ovf, cycle - cur.acc);
            end
          end else begin
            check("hold_result", 32'(out_result), 32'(cur.res));
            check("hold_ovf", 32'(out_ovf), 32'(cur.ovf));
          end
          check("in_ready_low_in_done", 32'(in_ready), 32'd0);
        end
        hs_pending = out_valid && out_ready;
        prev_valid = out_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !out_valid && sb_q.size() == 0) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL idle_timeout: got in_ready=%0b out_valid=%0b pending=%0d, expected idle", in_ready, out_valid, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Presents one op while idle; optionally keeps driving junk during BUSY.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int junk_cycles);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    sb_q.push_back(model(a, b, cycle));
    $display("op issued: a=%h b=%h", a, b);
    if (junk_cycles > 0) begin
      in_a = '1;
      in_b = W'($urandom);
      repeat (junk_cycles) tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_result", 32'(out_result), 32'd0);
      check("idle_ovf", 32'(out_ovf), 32'd0);
    end

    wait_idle(); do_op(16'h8752, 16'h1F73, 0);
    wait_idle(); do_op(16'h0000, 16'h8888, 0);
    wait_idle(); do_op(16'h8888, 16'h0000, 0);
    // Lanes: 0-(-8), -8-0, 5-5, -8-(-8)
    wait_idle(); do_op(16'h8580, 16'h8508, 0);

    // Backpressure
    wait_idle();
    out_ready = 1'b0;
    do_op(16'h1234, 16'h1111, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (6) tick();
    out_ready = 1'b1;
    wait_idle();

    // Operands driven during BUSY must be ignored
    do_op(16'h7777, 16'h1111, 2);
    wait_idle();

    // Reset in the middle of an op
    in_valid = 1'b1;
    in_a = 16'h7777;
    in_b = 16'h1111;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(out_result), 32'd0);
    check("midrst_ovf", 32'(out_ovf), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    wait_idle(); do_op(16'h5A3C, 16'hC3A5, 0);
    wait_idle();

    // Randomized ops with random backpressure
    bp_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wait_idle();
      do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
    end
    wait_idle();
    bp_mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psubsb_seq.md
Name: psubsb_seq

Overview:
Lane-serial packed saturating subtractor, the subtract counterpart of the packed saturating-add ALU op.
- Accepts two packed words of LANES signed 4-bit lanes through a valid/ready handshake.
- Computes one lane per cycle as sat(a_i − b_i), clamped to [−8, +7].
- Returns the packed result plus per-lane overflow flags through an output valid/ready handshake.
- Sits beside the add lane in the ALU datapath and frees it for the PSUBSB op.

Parameters:
- LANES, 4, number of 4-bit lanes per operand. Operand width W = 4*LANES. Legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- in_a  input  W  minuend, lane i = bits [4i+3:4i].
- in_b  input  W  subtrahend, same packing.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  W  packed saturated differences.
- out_ovf  output  LANES  bit i set if lane i saturated.

Behaviour:
- Reset (rst_n low, async, any state):
  - state=IDLE, lane_idx=0.
  - in_ready=1, out_valid=0, out_result=0, out_ovf=0.
  - Captured operands cleared.
  - Reset mid-operation aborts; no partial result is ever presented.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_a/in_b, clear out_result/out_ovf, lane_idx=0, go to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored and operands are not sampled.
  - Each cycle: compute lane lane_idx, write to out_result lane and out_ovf bit, lane_idx++.
  - When lane_idx==LANES−1 is written, go to DONE and reset lane_idx to 0.
- DONE:
  - out_valid=1, in_ready=0.
  - out_result and out_ovf held stable while out_ready=0 (arbitrary backpressure).
  - On out_ready: go to IDLE next cycle; out_valid drops.
  - No same-cycle accept of new operands. Back-to-back throughput is one op per LANES+2 cycles.
- Latency: out_valid rises exactly LANES cycles after the accepting clock edge (4 cycles for default).
- Lane arithmetic:
  - diff = a + ~b + 1, 4-bit, carry-out discarded.
  - pos_sat = ~a[3] & b[3] & diff[3] → result 4'b0111.
  - neg_sat = a[3] & ~b[3] & ~diff[3] → result 4'b1000.
  - Otherwise result = diff.
  - ovf bit = pos_sat | neg_sat.
- Boundary cases:
  - 0 − (−8) saturates to +7.
  - −8 − 0 = −8, no saturation.
  - x − x = 0, no saturation.
  - −8 − (−8) = 0, no saturation.
- out_ready asserted outside DONE has no effect.
- out_result/out_ovf are registered outputs; they are valid only while out_valid=1.

Decomposition:
- Shared ALU package:
  - Constants SAT_POS_4 = 4'b0111 and SAT_NEG_4 = 4'b1000 (the add lane uses the same constants).
  - LANE_W = 4.
  - State encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One combinational sub-module, psubsb_lane:
  - Inputs: 4-bit a, b. Outputs: 4-bit result, ovf.
  - Built on the existing 4-bit CLA adder with ~b and cin=1.
- The top level holds the FSM, lane counter, operand registers and lane-select/writeback muxing.

Test Plan:
- Reset then idle, no stimulus → in_ready=1, out_valid=0, out_result=0, out_ovf=0; hold 10 cycles, no change.
- Mixed lanes: in_a=16'h8752, in_b=16'h1F73, out_ready=1.
  - Expected out_result=16'h87EF (lanes 2−3=−1, 5−7=−2, 7−(−1)→+7, −8−1→−8) and out_ovf=4'b1100.
  - out_valid must rise exactly 4 cycles after accept.
- Positive saturation, all lanes: in_a=16'h0000, in_b=16'h8888 → out_result=16'h7777, out_ovf=4'b1111.
  - Same op with in_a=16'h8888, in_b=16'h0000 → out_result=16'h8888, out_ovf=4'b0000.
- Backpressure: in_a=16'h1234, in_b=16'h1111, out_ready=0 for 6 cycles after out_valid.
  - out_result=16'h0123, out_ovf=0, both stable throughout and in_ready=0.
  - Raise out_ready → out_valid falls next cycle and in_ready=1.
- Busy-ignore plus reset mid-op:
  - Accept 16'h7777−16'h1111, then drive in_valid with in_a=16'hFFFF during BUSY. Result must be 16'h6666 from the first operands only.
  - Repeat, asserting rst_n=0 at BUSY lane 2 → outputs clear immediately; no out_valid ever appears for that op; the next op completes normally.
